// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the EX-stage hazard/forwarding controller.
package pipeline_pkg;
  typedef enum logic {NORMAL = 1'b0, MULTI = 1'b1} estado_t;

  // Forward selects as {controle1, controle2}
  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b10;
  localparam logic [1:0] FW_WB  = 2'b01;

  localparam int LATENCIA_MULT_PADRAO = 4;
endpackage

// File: rtl/controle_hazard_if.sv
// ID/EX-side control inputs and hazard/forwarding outputs of the controller.
interface controle_hazard_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_usa_rt;
  logic       id_valido;
  logic [4:0] ex_destino;
  logic       ex_escreve_reg;
  logic       ex_le_memoria;
  logic       ex_multiciclo;
  logic       desvio_tomado;
  logic       controle1P;
  logic       controle2P;
  logic       controle1S;
  logic       controle2S;
  logic       stall_if_id;
  logic       bolha_id_ex;
  logic       stall_ex;
  logic       flush_if_id;

  modport master (
    output id_rs, id_rt, id_usa_rt, id_valido, ex_destino, ex_escreve_reg,
           ex_le_memoria, ex_multiciclo, desvio_tomado,
    input  controle1P, controle2P, controle1S, controle2S,
           stall_if_id, bolha_id_ex, stall_ex, flush_if_id
  );

  modport slave (
    input  id_rs, id_rt, id_usa_rt, id_valido, ex_destino, ex_escreve_reg,
           ex_le_memoria, ex_multiciclo, desvio_tomado,
    output controle1P, controle2P, controle1S, controle2S,
           stall_if_id, bolha_id_ex, stall_ex, flush_if_id
  );
endinterface

// File: rtl/detector_forward.sv
// Forwarding compare for one EX operand; MEM result wins over WB, $0 is never forwarded.
module detector_forward
  import pipeline_pkg::*;
(
  input  logic [4:0] i_ex_src,
  input  logic [4:0] i_mem_dest,
  input  logic       i_mem_escreve,
  input  logic [4:0] i_wb_dest,
  input  logic       i_wb_escreve,
  output logic [1:0] o_sel
);
  always_comb begin
    o_sel = FW_REG;
    if (i_mem_escreve && (i_mem_dest != 5'd0) && (i_mem_dest == i_ex_src))
      o_sel = FW_MEM;
    else if (i_wb_escreve && (i_wb_dest != 5'd0) && (i_wb_dest == i_ex_src))
      o_sel = FW_WB;
  end
endmodule

// File: rtl/controle_hazard.sv
// EX-stage hazard controller: operand forwarding, load-use stall, multi-cycle ALU hold
// and branch flush gating for the 5-stage MIPS pipeline.
module controle_hazard
  import pipeline_pkg::*;
#(
  parameter int LATENCIA_MULT = LATENCIA_MULT_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  controle_hazard_if.slave    bus
);
  localparam int            CW      = $clog2(LATENCIA_MULT);
  localparam logic [CW-1:0] CNT_INI = CW'(LATENCIA_MULT - 2);

  estado_t       r_estado;
  estado_t       w_estado_prox;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_ex_rs, r_ex_rt;
  logic [4:0]    r_mem_dest, r_wb_dest;
  logic          r_mem_escreve, r_wb_escreve;

  logic [1:0]    w_sel_rs, w_sel_rt;
  logic          w_stall_ex, w_lu, w_stall_if_id, w_bolha, w_flush;

  detector_forward u_fw_rs (
    .i_ex_src      (r_ex_rs),
    .i_mem_dest    (r_mem_dest),
    .i_mem_escreve (r_mem_escreve),
    .i_wb_dest     (r_wb_dest),
    .i_wb_escreve  (r_wb_escreve),
    .o_sel         (w_sel_rs)
  );

  detector_forward u_fw_rt (
    .i_ex_src      (r_ex_rt),
    .i_mem_dest    (r_mem_dest),
    .i_mem_escreve (r_mem_escreve),
    .i_wb_dest     (r_wb_dest),
    .i_wb_escreve  (r_wb_escreve),
    .o_sel         (w_sel_rt)
  );

  // FSM: state and occupancy counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= NORMAL;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_prox;
      if (r_estado == NORMAL && bus.ex_multiciclo)
        r_cnt <= CNT_INI;
      else if (r_estado == MULTI && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      NORMAL:  if (bus.ex_multiciclo) w_estado_prox = MULTI;
      MULTI:   if (r_cnt == '0)       w_estado_prox = NORMAL;
      default: w_estado_prox = NORMAL;
    endcase
  end

  // The op is released on the last MULTI cycle, so stall covers LATENCIA_MULT-1 cycles
  always_comb begin
    w_stall_ex = 1'b0;
    case (r_estado)
      NORMAL:  w_stall_ex = bus.ex_multiciclo;
      MULTI:   w_stall_ex = (r_cnt != '0);
      default: w_stall_ex = 1'b0;
    endcase
    if (reset) w_stall_ex = 1'b0;
  end

  assign w_lu = !reset && bus.id_valido && bus.ex_le_memoria && bus.ex_escreve_reg &&
                (bus.ex_destino != 5'd0) &&
                ((bus.ex_destino == bus.id_rs) ||
                 (bus.id_usa_rt && (bus.ex_destino == bus.id_rt)));

  assign w_stall_if_id = w_lu || w_stall_ex;
  assign w_bolha       = w_lu && !w_stall_ex;
  assign w_flush       = !reset && bus.desvio_tomado && !w_stall_if_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_mem_dest    <= '0;
      r_mem_escreve <= 1'b0;
      r_wb_dest     <= '0;
      r_wb_escreve  <= 1'b0;
    end else begin
      r_wb_dest    <= r_mem_dest;
      r_wb_escreve <= r_mem_escreve;
      if (w_stall_ex) begin
        r_mem_escreve <= 1'b0;
      end else begin
        r_mem_dest    <= bus.ex_destino;
        r_mem_escreve <= bus.ex_escreve_reg;
        if (w_bolha || w_flush) begin
          r_ex_rs <= '0;
          r_ex_rt <= '0;
        end else begin
          r_ex_rs <= bus.id_rs;
          r_ex_rt <= bus.id_rt;
        end
      end
    end
  end

  assign bus.controle1P  = !reset && w_sel_rs[1];
  assign bus.controle2P  = !reset && w_sel_rs[0];
  assign bus.controle1S  = !reset && w_sel_rt[1];
  assign bus.controle2S  = !reset && w_sel_rt[0];
  assign bus.stall_if_id = w_stall_if_id;
  assign bus.bolha_id_ex = w_bolha;
  assign bus.stall_ex    = w_stall_ex;
  assign bus.flush_if_id = w_flush;
endmodule

// File: tb/tb_controle_hazard.sv
// Bench for controle_hazard: directed vector table, multi-cycle/reset sequences,
// and randomized traffic checked against a cycle-level reference model.
module tb_controle_hazard;
  import pipeline_pkg::*;

  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controle_hazard_if bus();

  controle_hazard #(.LATENCIA_MULT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       usa;
    logic       val;
    logic [4:0] ex_d;
    logic       ex_w;
    logic       ex_ld;
    logic       ex_mc;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pipeline contents plus cycles the current EX op has spent in EX
  logic [4:0] m_ex_rs, m_ex_rt, m_mem_d, m_wb_d;
  logic       m_mem_w, m_wb_w;
  int         m_age;
  logic [7:0] last_act;

  function automatic logic [1:0] m_fw(input logic [4:0] src);
    if (m_mem_w && m_mem_d != 0 && m_mem_d == src) return 2'b10;
    if (m_wb_w && m_wb_d != 0 && m_wb_d == src)    return 2'b01;
    return 2'b00;
  endfunction

  // Bits: {c1P, c2P, c1S, c2S, stall_if_id, bolha_id_ex, stall_ex, flush_if_id}
  function automatic logic [7:0] model_out();
    logic st, lu, sif;
    if (reset) return 8'h00;
    st  = bus.ex_multiciclo && (m_age < LAT - 1);
    lu  = bus.id_valido && bus.ex_le_memoria && bus.ex_escreve_reg && bus.ex_destino != 0 &&
          (bus.ex_destino == bus.id_rs || (bus.id_usa_rt && bus.ex_destino == bus.id_rt));
    sif = lu || st;
    return {m_fw(m_ex_rs), m_fw(m_ex_rt), sif, lu && !st, st, bus.desvio_tomado && !sif};
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.controle1P, bus.controle2P, bus.controle1S, bus.controle2S,
            bus.stall_if_id, bus.bolha_id_ex, bus.stall_ex, bus.flush_if_id};
  endfunction

  task automatic model_step(input logic [7:0] e);
    if (reset) begin
      m_ex_rs = 0; m_ex_rt = 0; m_mem_d = 0; m_mem_w = 0; m_wb_d = 0; m_wb_w = 0; m_age = 0;
    end else begin
      m_wb_d = m_mem_d;
      m_wb_w = m_mem_w;
      if (e[1]) m_mem_w = 1'b0;
      else begin
        m_mem_d = bus.ex_destino;
        m_mem_w = bus.ex_escreve_reg;
        if (e[2] || e[0]) begin m_ex_rs = 0; m_ex_rt = 0; end
        else begin m_ex_rs = bus.id_rs; m_ex_rt = bus.id_rt; end
      end
      m_age = e[1] ? m_age + 1 : 0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    bus.id_rs          = v.id_rs;
    bus.id_rt          = v.id_rt;
    bus.id_usa_rt      = v.usa;
    bus.id_valido      = v.val;
    bus.ex_destino     = v.ex_d;
    bus.ex_escreve_reg = v.ex_w;
    bus.ex_le_memoria  = v.ex_ld;
    bus.ex_multiciclo  = v.ex_mc;
    bus.desvio_tomado  = v.br;
  endtask

  // One cycle: check at negedge against given or modelled value, then advance model
  task automatic cycle(input string name, input logic use_fixed, input logic [7:0] fixed);
    logic [7:0] e;
    @(negedge clock);
    e        = model_out();
    last_act = dut_out();
    check(name, last_act, use_fixed ? fixed : e);
    @(posedge clock);
    model_step(e);
    #1;
  endtask

  vec_t tab[15];
  vec_t v;
  int   n_st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst rs  rt  usa val exd  w  ld mc br  expected
    tab[0]  = '{1, 3, 3, 1, 1, 3, 1, 1, 1, 1, 8'b0000_0000};
    tab[1]  = '{0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 8'b0000_0000};
    tab[2]  = '{0, 3, 4, 1, 1, 3, 1, 0, 0, 0, 8'b0000_0000};
    tab[3]  = '{0, 7, 3, 1, 1, 6, 1, 0, 0, 0, 8'b1000_0000};
    tab[4]  = '{0, 0, 3, 1, 1, 3, 1, 0, 0, 0, 8'b0001_0000};
    tab[5]  = '{0, 5, 0, 1, 1, 5, 1, 0, 0, 0, 8'b0010_0000};
    tab[6]  = '{0, 5, 9, 1, 1, 5, 1, 0, 0, 0, 8'b1000_0000};
    tab[7]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 8'b1000_0000};
    tab[8]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 8'b0000_0000};
    tab[9]  = '{0, 1, 4, 1, 1, 4, 1, 1, 0, 0, 8'b0000_1100};
    tab[10] = '{0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 8'b0000_0000};
    tab[11] = '{0, 1, 4, 0, 1, 4, 1, 1, 0, 0, 8'b0001_0000};
    tab[12] = '{0, 7, 0, 0, 1, 7, 1, 1, 0, 1, 8'b0010_1100};
    tab[13] = '{0, 7, 0, 0, 1, 0, 0, 0, 0, 1, 8'b0000_0001};
    tab[14] = '{0, 2, 3, 0, 1, 0, 0, 0, 0, 0, 8'b0000_0000};

    m_ex_rs = 0; m_ex_rt = 0; m_mem_d = 0; m_mem_w = 0; m_wb_d = 0; m_wb_w = 0; m_age = 0;
    drive(tab[0]);
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(tab[i]);
      cycle($sformatf("tab%0d", i), 1'b1, tab[i].exp);
    end

    // Two back-to-back multi-cycle ops; EX reads $8 so a non-bubbled MEM write would forward
    v = '{0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    drive(v);
    cycle("mc_pre", 1'b0, 8'h00);
    n_st = 0;
    v = '{0, 8, 8, 0, 1, 8, 1, 0, 1, 0, 8'h00};
    for (int k = 0; k < 2 * LAT; k++) begin
      drive(v);
      cycle($sformatf("mc%0d", k), 1'b0, 8'h00);
      n_st += int'(last_act[1]);
    end
    check("mc_stall_count", 8'(n_st), 8'(2 * (LAT - 1)));

    // Reset on the 2nd MULTI cycle, then idle pipeline
    for (int k = 0; k < 2; k++) begin
      drive(v);
      cycle($sformatf("rm%0d", k), 1'b0, 8'h00);
    end
    v.rst = 1'b1;
    drive(v);
    cycle("rst_mid_multi", 1'b1, 8'h00);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    for (int k = 0; k < 2; k++) begin
      drive(v);
      cycle($sformatf("idle_after_rst%0d", k), 1'b1, 8'h00);
    end

    // Random traffic; EX fields are held while the model says the op is still occupying EX
    for (int k = 0; k < 400; k++) begin
      v.rst   = ($urandom_range(0, 63) == 0);
      v.id_rs = 5'($urandom_range(0, 3));
      v.id_rt = 5'($urandom_range(0, 3));
      v.usa   = 1'($urandom_range(0, 1));
      v.val   = ($urandom_range(0, 7) != 0);
      v.br    = ($urandom_range(0, 3) == 0);
      if (m_age == 0) begin
        v.ex_d  = 5'($urandom_range(0, 3));
        v.ex_w  = 1'($urandom_range(0, 1));
        v.ex_ld = 1'($urandom_range(0, 1));
        v.ex_mc = ($urandom_range(0, 5) == 0);
      end
      drive(v);
      cycle($sformatf("rnd%0d", k), 1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
